// File: rtl/fp_pkg.sv
// IEEE-754 single-precision field layout shared by the pre-MAP decode and the
// post-MAP encode.
package fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

endpackage

// File: rtl/post_map_encode_if.sv
// Valid/ready stream bundle; master drives data/valid, slave drives ready.
interface post_map_encode_if #(
  parameter int W = 32
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/norm_shift32.sv
// Leading-zero count and left-normalize of a 32-bit magnitude, MSB-first
// halving: each step tests the upper half of what remains and shifts it out.
module norm_shift32 (
  input  logic [31:0] mag_i,
  output logic [4:0]  n_o,
  output logic [31:0] norm_o
);

  logic [31:0] v;
  logic [4:0]  n;

  // NOTE: blocking assignments here are intentional -- each step must see the
  // value shifted by the previous step within the same evaluation.
  always_comb begin
    v = mag_i;
    n = '0;
    if (v[31:16] == '0) begin n[4] = 1'b1; v = v << 16; end
    if (v[31:24] == '0) begin n[3] = 1'b1; v = v << 8;  end
    if (v[31:28] == '0) begin n[2] = 1'b1; v = v << 4;  end
    if (v[31:30] == '0) begin n[1] = 1'b1; v = v << 2;  end
    if (v[31]    == 1'b0) begin n[0] = 1'b1; v = v << 1; end
    n_o    = n;
    norm_o = v;
  end

endmodule

// File: rtl/post_map_encode.sv
// Signed Q(32-FRAC_W).FRAC_W fixed point to IEEE-754 single, three registered
// stages (sign/magnitude, normalize, round/pack) with bubble-collapsing flow.
module post_map_encode #(
  parameter int FRAC_W   = 30,
  parameter int EXP_BIAS = fp_pkg::EXP_BIAS
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_fix,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [31:0] o_fp,
  output logic        o_valid,
  input  logic        i_ready
);

  import fp_pkg::*;

  localparam logic [8:0] EXP_BASE  = 9'(EXP_BIAS + 31 - FRAC_W);
  localparam int         GUARD_BIT = 31 - MANT_W - 1;

  // Stage registers
  logic        s1_valid_q, s1_sign_q, s1_zero_q;
  logic [31:0] s1_mag_q;
  logic        s2_valid_q, s2_sign_q, s2_zero_q;
  logic [4:0]  s2_n_q;
  logic [31:0] s2_norm_q;
  logic        s3_valid_q;
  logic [31:0] fp_q;

  logic        s1_load, s2_load, s3_load;
  logic [31:0] mag_d;
  logic [4:0]  n_d;
  logic [31:0] norm_d;

  // A stage may load when empty or when its successor drains it this cycle;
  // this chain is the only path from i_ready to o_ready.
  assign s3_load = !s3_valid_q || i_ready;
  assign s2_load = !s2_valid_q || s3_load;
  assign s1_load = !s1_valid_q || s2_load;
  assign o_ready = s1_load;

  assign mag_d = i_fix[SIGN_BIT] ? -i_fix : i_fix;

  norm_shift32 u_norm (
    .mag_i  (s1_mag_q),
    .n_o    (n_d),
    .norm_o (norm_d)
  );

  // Round/pack, fed straight from the S2 registers
  logic [MANT_W-1:0] mant_pre;
  logic              guard, sticky, round_up;
  logic [MANT_W:0]   mant_sum;
  logic [8:0]        exp_fin;
  fp32_t             fp_d;
  logic              fp_unused;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned and a latch cannot be inferred.
  always_comb begin
    mant_pre = s2_norm_q[30 -: MANT_W];
    guard    = s2_norm_q[GUARD_BIT];
    sticky   = |s2_norm_q[GUARD_BIT-1:0];
    round_up = guard && (sticky || mant_pre[0]);
    mant_sum = {1'b0, mant_pre} + {{MANT_W{1'b0}}, round_up};
    // A carry out of the mantissa leaves mant_sum[MANT_W-1:0] at zero and
    // bumps the exponent by one.
    exp_fin  = EXP_BASE - {4'b0, s2_n_q} + {8'b0, mant_sum[MANT_W]};
    fp_d     = '0;
    if (!s2_zero_q) begin
      fp_d.sign = s2_sign_q;
      fp_d.exp  = exp_fin[EXP_W-1:0];
      fp_d.mant = mant_sum[MANT_W-1:0];
    end
  end

  // Exponent never reaches 256 for legal FRAC_W; norm[31] is the implicit one.
  assign fp_unused = ^{exp_fin[8], s2_norm_q[31]};

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's value from before the clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_mag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_n_q     <= '0;
      s2_norm_q  <= '0;
      s3_valid_q <= 1'b0;
      fp_q       <= FP_ZERO;
    end else begin
      if (s1_load) begin
        s1_valid_q <= i_valid;
        if (i_valid) begin
          s1_sign_q <= i_fix[SIGN_BIT];
          s1_zero_q <= (i_fix == '0);
          s1_mag_q  <= mag_d;
        end
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_sign_q <= s1_sign_q;
          s2_zero_q <= s1_zero_q;
          s2_n_q    <= n_d;
          s2_norm_q <= norm_d;
        end
      end
      if (s3_load) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          fp_q <= fp_d;
        end
      end
    end
  end

  assign o_fp    = fp_q;
  assign o_valid = s3_valid_q;

endmodule

// File: tb/tb_post_map_encode.sv
// Directed bench for post_map_encode (FRAC_W=30): values, rounding, latency,
// backpressure, bubbles and asynchronous reset with items in flight.
module tb_post_map_encode;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          out_cyc_q[$];
  int          acc_cyc_q[$];

  post_map_encode_if #(.W(32)) in_if  ();
  post_map_encode_if #(.W(32)) out_if ();

  post_map_encode #(
    .FRAC_W   (30),
    .EXP_BIAS (127)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_fix   (in_if.data),
    .i_valid (in_if.valid),
    .o_ready (in_if.ready),
    .o_fp    (out_if.data),
    .o_valid (out_if.valid),
    .i_ready (out_if.ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output transfers are recorded mid-cycle; they complete at the next edge.
  always @(negedge clk) begin
    if (rst_n && out_if.valid && out_if.ready) begin
      got_q.push_back(out_if.data);
      out_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Offer one operand; returns just after the edge on which it was accepted.
  task automatic push(input logic [31:0] d, input logic [31:0] expected);
    int  t    = 0;
    bit  done = 1'b0;
    in_if.data  = d;
    in_if.valid = 1'b1;
    while (!done && t < 50) begin
      @(negedge clk);
      done = in_if.ready;
      if (done) acc_cyc_q.push_back(cyc);
      @(posedge clk);
      #1;
      t++;
    end
    in_if.valid = 1'b0;
    if (done) exp_q.push_back(expected);
    else check("push_timeout", 32'(done), 32'd1);
  endtask

  // Wait for the expected results, allow stragglers to show, then compare.
  task automatic drain(input string tag, input bit chk_lat);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_q.size()) check($sformatf("%s_val%0d", tag, i), got_q[i], exp_q[i]);
    end
    if (chk_lat) begin
      foreach (acc_cyc_q[i]) begin
        if (i < out_cyc_q.size())
          check($sformatf("%s_lat%0d", tag, i), 32'(out_cyc_q[i] - acc_cyc_q[i]), 32'd3);
      end
    end
    got_q.delete();
    exp_q.delete();
    out_cyc_q.delete();
    acc_cyc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp_in  [6];
    logic [31:0] bp_out [6];
    int          acc;

    bp_in  = '{32'h4000_0000, 32'h2000_0000, 32'hE000_0000,
               32'h6000_0000, 32'h0000_0002, 32'hFFFF_FFFE};
    bp_out = '{32'h3F80_0000, 32'h3F00_0000, 32'hBF00_0000,
               32'h3FC0_0000, 32'h3100_0000, 32'hB100_0000};

    rst_n        = 1'b0;
    in_if.data   = '0;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;

    // Reset state
    #3;
    check("rst_o_valid", 32'(out_if.valid), 32'd0);
    check("rst_o_fp",    out_if.data,       32'h0);
    check("rst_o_ready", 32'(in_if.ready),  32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back stream, 3-cycle latency each
    push(32'h4000_0000, 32'h3F80_0000);
    push(32'hC000_0000, 32'hBF80_0000);
    push(32'h8000_0000, 32'hC000_0000);
    push(32'h0000_0001, 32'h3080_0000);
    drain("stream", 1'b1);

    // Zero, small negative, rounding cases
    push(32'h0000_0000, 32'h0000_0000);
    push(32'hFFFF_FFFF, 32'hB080_0000);
    push(32'h7FFF_FFFF, 32'h4000_0000);  // mantissa carry, exponent +1
    push(32'h4000_0040, 32'h3F80_0000);  // exact tie, mantissa even: kept
    push(32'h4000_00C0, 32'h3F80_0002);  // 1.5 ulp tie: rounds to even 2
    push(32'h4000_00A0, 32'h3F80_0001);  // guard clear: truncates
    push(32'h4000_0041, 32'h3F80_0001);  // guard + sticky: rounds up
    push(32'h7FFF_FF80, 32'h3FFF_FFFF);  // largest mantissa, no rounding
    drain("round", 1'b0);

    // Backpressure: downstream stalled while six operands are offered
    out_if.ready = 1'b0;
    acc = 0;
    repeat (6) begin
      in_if.valid = 1'b1;
      in_if.data  = bp_in[acc];
      @(negedge clk);
      if (in_if.ready) acc++;
      @(posedge clk);
      #1;
    end
    in_if.valid = 1'b0;
    check("bp_accepts", 32'(acc), 32'd3);
    check("bp_o_ready", 32'(in_if.ready), 32'd0);
    check("bp_o_valid", 32'(out_if.valid), 32'd1);
    check("bp_hold0", out_if.data, bp_out[0]);
    repeat (2) @(posedge clk);
    #1;
    check("bp_hold1", out_if.data, bp_out[0]);
    for (int i = 0; i < 3; i++) exp_q.push_back(bp_out[i]);
    out_if.ready = 1'b1;
    for (int i = 3; i < 6; i++) push(bp_in[i], bp_out[i]);
    drain("bp", 1'b0);

    // Bubbles on the input with random downstream readiness
    fork
      begin
        repeat (30) begin
          out_if.ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        out_if.ready = 1'b1;
      end
      begin
        push(32'h0800_0000, 32'h3E00_0000);
        @(posedge clk); #1;
        push(32'hF800_0000, 32'hBE00_0000);
        @(posedge clk); #1;
        push(32'h0001_0000, 32'h3880_0000);
        @(posedge clk); #1;
        push(32'h7FFF_FF80, 32'h3FFF_FFFF);
      end
    join
    drain("bubble", 1'b0);

    // Refill at full rate once downstream is ready again
    push(32'h2000_0000, 32'h3F00_0000);
    push(32'hE000_0000, 32'hBF00_0000);
    push(32'h0000_0001, 32'h3080_0000);
    drain("refill", 1'b1);

    // Asynchronous reset with three items in flight
    push(32'h4000_0000, 32'h3F80_0000);
    push(32'h6000_0000, 32'h3FC0_0000);
    push(32'hC000_0000, 32'hBF80_0000);
    check("inflight_o_valid", 32'(out_if.valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_o_valid", 32'(out_if.valid), 32'd0);
    check("arst_o_fp",    out_if.data,       32'h0);
    exp_q.delete();
    acc_cyc_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(32'h0000_0002, 32'h3100_0000);
    drain("post_rst", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
